// File: rtl/mem_bus_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mem_bus_responder_pkg
// Brief  : Shared FSM encoding, I/O address map and decode types.
// Rev    : 1.0  initial release
// ============================================================================
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_RAM = 2'd1,
    ST_RD_IO  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_COUNTER  = 2'd0,
    SEL_LEDS     = 2'd1,
    SEL_SWITCHES = 2'd2,
    SEL_NONE     = 2'd3
  } io_sel_t;

  localparam logic [15:0] IO_COUNTER  = 16'hFFF0;
  localparam logic [15:0] IO_LEDS     = 16'hFFF1;
  localparam logic [15:0] IO_SWITCHES = 16'hFFF2;
  localparam int          LED_W       = 10;

endpackage
`default_nettype wire

// File: rtl/mem_bus_responder_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mem_bus_responder_sync2
// Brief  : Two-flop synchroniser for asynchronous level inputs.
// Rev    : 1.0  initial release
// ============================================================================
module mem_bus_responder_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      q      <= '0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mem_bus_responder
// Brief  : Memory-bus responder: external sync RAM plus counter/LED/switch I/O.
// Rev    : 1.0  initial release
// ============================================================================
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [WIDTH-1:0]  memAdr,
  input  logic [WIDTH-1:0]  writeData,
  output logic [WIDTH-1:0]  readData,
  output logic              memReady,
  output logic [RAM_AW-1:0] ramAdr,
  output logic              ramWe,
  output logic [WIDTH-1:0]  ramWData,
  input  logic [WIDTH-1:0]  ramRData,
  input  logic [LED_W-1:0]  switches,
  output logic [LED_W-1:0]  leds,
  output logic              errFlag
);

  state_t           r_state, w_state_nxt;
  io_sel_t          w_io_sel;
  logic [WIDTH-1:0] r_counter, r_io_data, w_io_value;
  logic [LED_W-1:0] w_sw_sync;
  logic             w_is_ram, w_ram_we, w_led_we, w_io_load;
  logic             w_rd_ram, w_rd_io, w_err_set, w_ready;

  mem_bus_responder_sync2 #(.WIDTH(LED_W)) u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (switches),
    .q     (w_sw_sync)
  );

  assign w_is_ram = ((memAdr >> RAM_AW) == '0);
  assign ramAdr   = memAdr[RAM_AW-1:0];
  assign ramWData = writeData;
  assign ramWe    = w_ram_we & ~reset;
  assign memReady = w_ready;

  always_comb begin
    w_io_sel = SEL_NONE;
    if (memAdr == WIDTH'(IO_COUNTER))       w_io_sel = SEL_COUNTER;
    else if (memAdr == WIDTH'(IO_LEDS))     w_io_sel = SEL_LEDS;
    else if (memAdr == WIDTH'(IO_SWITCHES)) w_io_sel = SEL_SWITCHES;
  end

  always_comb begin
    case (w_io_sel)
      SEL_COUNTER:  w_io_value = r_counter;
      SEL_LEDS:     w_io_value = WIDTH'(leds);
      SEL_SWITCHES: w_io_value = WIDTH'(w_sw_sync);
      default:      w_io_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_led_we    = 1'b0;
    w_io_load   = 1'b0;
    w_rd_ram    = 1'b0;
    w_rd_io     = 1'b0;
    w_err_set   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (memRead && memWrite) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (memRead) begin
          // I/O value is frozen at the sample edge so counter reads see that edge
          w_io_load   = 1'b1;
          w_state_nxt = w_is_ram ? ST_RD_RAM : ST_RD_IO;
        end else if (memWrite) begin
          w_ram_we    = w_is_ram;
          w_led_we    = (w_io_sel == SEL_LEDS);
          w_state_nxt = ST_DONE;
        end
      end
      ST_RD_RAM: begin
        w_rd_ram    = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_RD_IO: begin
        w_rd_io     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_ready     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
    if ((r_state != ST_IDLE) && (memRead || memWrite)) w_err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readData  <= '0;
      leds      <= '0;
      errFlag   <= 1'b0;
      r_counter <= '0;
      r_io_data <= '0;
    end else begin
      r_counter <= r_counter + WIDTH'(1);
      if (w_io_load) r_io_data <= w_io_value;
      if (w_rd_ram)     readData <= ramRData;
      else if (w_rd_io) readData <= r_io_data;
      if (w_led_we)  leds    <= writeData[LED_W-1:0];
      if (w_err_set) errFlag <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mem_bus_responder
// Brief  : Self-checking bench: vector table, corner sequences, random ops.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset, memRead, memWrite;
  logic [15:0] memAdr, writeData, readData, ramWData, ramRData;
  logic        memReady, ramWe, errFlag;
  logic [9:0]  ramAdr, switches, leds;
  logic        ram_init;

  int checks   = 0;
  int failures = 0;

  // external synchronous RAM, 1-cycle read latency
  logic [15:0] ram [0:1023];
  // reference model state
  logic [15:0] m_ram [0:1023];
  logic [9:0]  m_leds, m_sw;
  logic [15:0] m_rdata;
  logic        m_err;
  int unsigned cyc;

  mem_bus_responder #(.WIDTH(16), .RAM_AW(10)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .memAdr(memAdr), .writeData(writeData), .readData(readData),
    .memReady(memReady), .ramAdr(ramAdr), .ramWe(ramWe),
    .ramWData(ramWData), .ramRData(ramRData), .switches(switches),
    .leds(leds), .errFlag(errFlag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'h0000;
    end else begin
      if (ramWe) ram[ramAdr] <= ramWData;
      ramRData <= ram[ramAdr];
    end
  end

  // clocks elapsed since the last reset edge
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a, input logic [15:0] cnt);
    if (a < 16'd1024)        return m_ram[a[9:0]];
    else if (a == 16'hFFF0)  return cnt;
    else if (a == 16'hFFF1)  return {6'b0, m_leds};
    else if (a == 16'hFFF2)  return {6'b0, m_sw};
    return 16'h0000;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d);
    if (a < 16'd1024)       m_ram[a[9:0]] = d;
    else if (a == 16'hFFF1) m_leds = d[9:0];
  endtask

  task automatic bus_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input string tag);
    logic [15:0] cnt;
    logic        exp_we;
    int          exp_lat, lat;
    @(negedge clk);
    memRead = rd; memWrite = wr; memAdr = a; writeData = d;
    cnt    = cyc[15:0];
    exp_we = wr && !rd && (a < 16'd1024);
    #1;
    chk({tag, " ramWe"}, 32'(ramWe), 32'(exp_we));
    if (exp_we) chk({tag, " ramAdr"}, 32'(ramAdr), 32'(a[9:0]));
    if (rd && wr) begin
      m_err = 1'b1; exp_lat = 0;
    end else if (rd) begin
      m_rdata = model_read(a, cnt); exp_lat = 1;
    end else begin
      model_write(a, d); exp_lat = 0;
    end
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      if (memReady) begin lat = i; break; end
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " readData"}, 32'(readData), 32'(m_rdata));
    chk({tag, " leds"}, 32'(leds), 32'(m_leds));
    chk({tag, " errFlag"}, 32'(errFlag), 32'(m_err));
    if (lat >= 0) begin
      @(posedge clk); #1;
      chk({tag, " ready pulse width"}, 32'(memReady), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    m_rdata = 16'h0; m_leds = 10'h0; m_err = 1'b0; m_sw = 10'h0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [9:0]  exp_leds;
  } vec_t;

  vec_t tab [17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, d;
    int          r, kind;

    reset = 1'b1; ram_init = 1'b1; memRead = 1'b0; memWrite = 1'b1;
    memAdr = 16'h0005; writeData = 16'h03FF; switches = 10'h000;
    for (int i = 0; i < 1024; i++) m_ram[i] = 16'h0000;
    m_rdata = 16'h0; m_leds = 10'h0; m_err = 1'b0; m_sw = 10'h0;

    // reset dominates strobes
    repeat (3) @(posedge clk);
    #1;
    chk("reset ramWe", 32'(ramWe), 32'd0);
    memAdr = 16'hFFF1;
    @(posedge clk); #1;
    chk("reset leds", 32'(leds), 32'd0);
    chk("reset readData", 32'(readData), 32'd0);
    chk("reset memReady", 32'(memReady), 32'd0);
    chk("reset errFlag", 32'(errFlag), 32'd0);
    memWrite = 1'b0; ram_init = 1'b0;
    @(negedge clk); reset = 1'b0;

    switches = 10'h2AA;
    repeat (3) @(posedge clk);
    m_sw = 10'h2AA;

    tab[0]  = '{1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 10'h000};
    tab[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 10'h000};
    tab[2]  = '{1'b0, 1'b1, 16'hFFF1, 16'h03A5, 16'h1234, 10'h3A5};
    tab[3]  = '{1'b1, 1'b0, 16'hFFF1, 16'h0000, 16'h03A5, 10'h3A5};
    tab[4]  = '{1'b1, 1'b0, 16'hFFF2, 16'h0000, 16'h02AA, 10'h3A5};
    tab[5]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 10'h3A5};
    tab[6]  = '{1'b0, 1'b1, 16'hFFF0, 16'hAAAA, 16'h0000, 10'h3A5};
    tab[7]  = '{1'b0, 1'b1, 16'h03FF, 16'hBEEF, 16'h0000, 10'h3A5};
    tab[8]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hBEEF, 10'h3A5};
    tab[9]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 10'h3A5};
    tab[10] = '{1'b0, 1'b1, 16'hFFF1, 16'hFFFF, 16'h0000, 10'h3FF};
    tab[11] = '{1'b1, 1'b0, 16'hFFF1, 16'h0000, 16'h03FF, 10'h3FF};
    tab[12] = '{1'b0, 1'b1, 16'hFFF2, 16'h0155, 16'h03FF, 10'h3FF};
    tab[13] = '{1'b1, 1'b0, 16'hFFF2, 16'h0000, 16'h02AA, 10'h3FF};
    tab[14] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 10'h3FF};
    tab[15] = '{1'b0, 1'b1, 16'h0000, 16'h0F0F, 16'h1234, 10'h3FF};
    tab[16] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 10'h3FF};

    foreach (tab[i]) begin
      bus_op(tab[i].rd, tab[i].wr, tab[i].adr, tab[i].wdata, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table readData", i), 32'(readData), 32'(tab[i].exp_rdata));
      chk($sformatf("vec%0d table leds", i), 32'(leds), 32'(tab[i].exp_leds));
    end

    // counter keeps counting despite the earlier write to 0xFFF0
    bus_op(1'b1, 1'b0, 16'hFFF0, 16'h0, "counter read");

    // simultaneous strobes: no access, sticky error
    bus_op(1'b1, 1'b1, 16'h0005, 16'h5555, "both strobes");
    bus_op(1'b1, 1'b0, 16'h0005, 16'h0, "read after both");
    chk("both no RAM write", 32'(readData), 32'h1234);

    // reset while in RD_RAM aborts the access
    @(negedge clk); memRead = 1'b1; memAdr = 16'h0005;
    @(posedge clk); #1; memRead = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort memReady", 32'(memReady), 32'd0);
    chk("abort readData", 32'(readData), 32'd0);
    chk("abort errFlag cleared", 32'(errFlag), 32'd0);
    @(negedge clk); reset = 1'b0;
    m_rdata = 16'h0; m_leds = 10'h0; m_err = 1'b0; m_sw = 10'h0;
    @(posedge clk); #1;
    chk("abort no late ready", 32'(memReady), 32'd0);
    repeat (3) @(posedge clk);
    m_sw = 10'h2AA;
    bus_op(1'b1, 1'b0, 16'h0005, 16'h0, "read after abort");

    // strobe while busy is ignored but flagged
    @(negedge clk); memRead = 1'b1; memAdr = 16'h0005;
    @(posedge clk); #1; memRead = 1'b0;
    @(negedge clk); memWrite = 1'b1; memAdr = 16'h0006; writeData = 16'hDEAD;
    #1;
    chk("busy ramWe", 32'(ramWe), 32'd0);
    @(posedge clk); #1; memWrite = 1'b0;
    chk("busy memReady", 32'(memReady), 32'd1);
    chk("busy readData", 32'(readData), 32'h1234);
    chk("busy errFlag", 32'(errFlag), 32'd1);
    m_err = 1'b1; m_rdata = 16'h1234;
    @(posedge clk); #1;
    bus_op(1'b1, 1'b0, 16'h0006, 16'h0, "busy write dropped");

    // counter wrap
    do_reset();
    repeat (3) @(posedge clk);
    m_sw = 10'h2AA;
    bus_op(1'b1, 1'b0, 16'hFFF0, 16'h0, "counter early");
    repeat (65536) @(posedge clk);
    bus_op(1'b1, 1'b0, 16'hFFF0, 16'h0, "counter wrapped");
    chk("counter wrapped small", 32'(readData < 16'd64), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 0) begin
        switches = 10'($urandom);
        repeat (3) @(posedge clk);
        m_sw = switches;
      end
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      a = 16'($urandom_range(0, 1023));
      else if (kind == 1) a = 16'h FFF0 + 16'($urandom_range(0, 2));
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(1024, 16'hFFEF));
      else                a = 16'($urandom_range(16'hFFF3, 16'hFFFF));
      d = 16'($urandom);
      r = int'($urandom_range(0, 15));
      if (r == 0)     bus_op(1'b1, 1'b1, a, d, $sformatf("rnd%0d both", n));
      else if (r < 8) bus_op(1'b1, 1'b0, a, d, $sformatf("rnd%0d rd", n));
      else            bus_op(1'b0, 1'b1, a, d, $sformatf("rnd%0d wr", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data and address width.
REQ-002 SHALL have parameter RAM_AW, default 10, RAM word-address width (RAM depth 2^RAM_AW).
REQ-003 SHALL have port clk, input, 1, single clock; all state on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port memRead, input, 1, read request strobe from the controller.
REQ-006 SHALL have port memWrite, input, 1, write request strobe from the controller.
REQ-007 SHALL have port memAdr, input, WIDTH, word address.
REQ-008 SHALL have port writeData, input, WIDTH, store data.
REQ-009 SHALL have port readData, output, WIDTH, registered load/fetch data.
REQ-010 SHALL have port memReady, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port ramAdr, output, RAM_AW; ramWe, output, 1; ramWData, output, WIDTH; ramRData, input, WIDTH: external synchronous single-port RAM (1-cycle read).
REQ-012 SHALL have port switches, input, 10, asynchronous board switches.
REQ-013 SHALL have port leds, output, 10, registered LED drive.
REQ-014 SHALL have port errFlag, output, 1, sticky protocol-error flag.

Function
REQ-015 Address map: 0x0000..2^RAM_AW-1 RAM; 0xFFF0 cycle counter (RO); 0xFFF1 LED register (RW, bits 9:0, upper bits read 0); 0xFFF2 synchronised switches (RO, zero-extended); all else unmapped.
REQ-016 FSM states IDLE, RD_RAM, RD_IO, DONE; request sampled only in IDLE.
REQ-017 IDLE + memRead (RAM addr) -> RD_RAM; ramAdr = memAdr[RAM_AW-1:0] driven same cycle.
REQ-018 RD_RAM: readData <= ramRData at next edge -> DONE; memReady high during DONE (read sampled at edge E, data valid and memReady high for the cycle after edge E+1).
REQ-019 IDLE + memRead (I/O or unmapped) -> RD_IO; readData <= selected I/O value (unmapped = 0) -> DONE; same 2-edge latency as RAM.
REQ-020 IDLE + memWrite: RAM addr -> ramWe=1 that cycle; 0xFFF1 -> leds <= writeData[9:0] at edge E; RO/unmapped addr -> discarded; state -> DONE, memReady high the cycle after edge E.
REQ-021 DONE -> IDLE unconditionally; memReady high only in DONE.
REQ-022 memRead and memWrite both high in IDLE: no access, errFlag <= 1, state -> DONE (memReady still pulses), readData unchanged.
REQ-023 Any strobe while not IDLE: ignored, errFlag <= 1.
REQ-024 readData holds last completed read value until the next read completes; writes never alter it.
REQ-025 ramWe SHALL be 0 except the single IDLE write cycle to a RAM address; ramWData = writeData combinationally.
REQ-026 Cycle counter: WIDTH-bit, +1 every clk, wraps 0xFFFF -> 0x0000; read returns value at sample edge E.
REQ-027 switches pass a 2-flop synchroniser before use.

Reset
REQ-028 reset SHALL force state IDLE, readData 0, memReady 0, leds 0, errFlag 0, counter 0, synchroniser flops 0, ramWe 0.
REQ-029 reset mid-access SHALL abort it: no memReady pulse, readData 0, no LED update.
REQ-030 reset SHALL dominate any simultaneous strobe.

Structure
REQ-031 Shared package SHALL hold FSM state encoding and address constants (IO_COUNTER 0xFFF0, IO_LEDS 0xFFF1, IO_SWITCHES 0xFFF2).
REQ-032 One sub-module SHALL be natural: sync2 (two-flop synchroniser, parameterised width); RAM stays external.

Verification
REQ-033 Write 0x1234 to 0x0005, then read 0x0005 -> ramWe one cycle; read memReady after 2 edges, readData 0x1234.
REQ-034 Write 0x03A5 to 0xFFF1 -> leds 0x3A5 next edge; read 0xFFF1 -> readData 0x03A5.
REQ-035 switches=0x2AA, wait 3 cycles, read 0xFFF2 -> readData 0x02AA.
REQ-036 Read 0x8000 (unmapped) -> readData 0x0000, memReady pulses; write 0xFFF0 -> counter unaffected.
REQ-037 memRead and memWrite high together -> errFlag 1, ramWe 0, memReady pulses; errFlag stays 1 until reset.
REQ-038 Assert reset during RD_RAM -> no memReady, readData 0, state IDLE; counter read 0xFFFF+1 cycles later shows wrap to small value.
